// File: rtl/sqrt_pkg.sv
// Shared definitions for the digit-by-digit square-root controller and its datapath wrapper.
// State encodings, control-strobe payload and iteration sizing helpers.
package sqrt_pkg;

    localparam int unsigned SQRT_WIDTH = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SHIFT  = 3'd2,
        S_CHECK  = 3'd3,
        S_UPDATE = 3'd4,
        S_DONE   = 3'd5
    } sqrt_state_e;

    // Datapath control strobes driven by the controller each cycle.
    typedef struct packed {
        logic rst_ld;
        logic shift;
        logic lda2;
        logic q_shift;
        logic q_bit;
    } sqrt_ctrl_t;

    function automatic int unsigned sqrt_iter(input int unsigned width);
        return width / 2;
    endfunction

    function automatic int unsigned sqrt_cnt_w(input int unsigned width);
        return $clog2(width / 2) + 1;
    endfunction

endpackage

// File: rtl/sqrt_iter_cnt.sv
// Iteration counter for the square-root controller: cleared on LOAD, bumped on UPDATE,
// saturating at ITER so the debug count never wraps.
module sqrt_iter_cnt
    import sqrt_pkg::*;
#(
    parameter int unsigned ITER  = sqrt_iter(SQRT_WIDTH),
    parameter int unsigned CNT_W = sqrt_cnt_w(SQRT_WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_count,
    output logic             o_last_c
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && (r_count != CNT_W'(ITER))) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_last_c = (r_count == CNT_W'(ITER - 1));

endmodule

// File: rtl/sqrt_ctrl.sv
// Control FSM for the digit-by-digit integer square-root datapath (start/busy/done handshake).
// Optional sticky completion interrupt with irq/irq_ack ports when SQRT_CTRL_IRQ_EN is defined.
module sqrt_ctrl
    import sqrt_pkg::*;
#(
    parameter  int unsigned WIDTH = SQRT_WIDTH,
    localparam int unsigned ITER  = sqrt_iter(WIDTH),
    localparam int unsigned CNT_W = sqrt_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start,
    input  logic             sub_neg,
`ifdef SQRT_CTRL_IRQ_EN
    input  logic             irq_ack,
    output logic             irq,
`endif
    output logic             rst_ld,
    output logic             shift,
    output logic             lda2,
    output logic             q_shift,
    output logic             q_bit,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] iter
);

    sqrt_state_e      r_state;
    sqrt_state_e      w_next;
    sqrt_ctrl_t       r_ctrl;
    sqrt_ctrl_t       w_ctrl;
    logic             r_busy;
    logic             w_busy;
    logic             r_done;
    logic             w_done;
    logic [CNT_W-1:0] w_count;
    logic             w_last_c;

    sqrt_iter_cnt #(
        .ITER  (ITER),
        .CNT_W (CNT_W)
    ) u_iter_cnt (
        .clk      (clk),
        .resetn   (resetn),
        .i_clr    (r_state == S_LOAD),
        .i_inc    (r_state == S_UPDATE),
        .o_count  (w_count),
        .o_last_c (w_last_c)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state, plus the strobes that belong to that next state; they are registered
    // below so every output is a clean flop with no input-to-output path.
    always_comb begin
        w_next = r_state;
        w_ctrl = '0;
        w_busy = 1'b0;
        w_done = 1'b0;

        case (r_state)
            S_IDLE:   if (start) w_next = S_LOAD;
            S_LOAD:   w_next = S_SHIFT;
            S_SHIFT:  w_next = S_CHECK;
            S_CHECK:  w_next = S_UPDATE;
            S_UPDATE: w_next = w_last_c ? S_DONE : S_SHIFT;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase

        // Entering UPDATE captures sub_neg at the end of CHECK, after the comparator settled.
        case (w_next)
            S_LOAD:   w_ctrl.rst_ld = 1'b1;
            S_SHIFT:  w_ctrl.shift  = 1'b1;
            S_UPDATE: begin
                w_ctrl.q_shift = 1'b1;
                w_ctrl.q_bit   = ~sub_neg;
                w_ctrl.lda2    = ~sub_neg;
            end
            S_DONE:   w_done = 1'b1;
            default:  ;
        endcase

        w_busy = (w_next != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ctrl <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_ctrl <= w_ctrl;
            r_busy <= w_busy;
            r_done <= w_done;
        end
    end

`ifdef SQRT_CTRL_IRQ_EN
    logic r_irq;

    // Held set throughout the DONE cycle so an ack landing on that cycle loses.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_irq <= 1'b0;
        end else if ((w_next == S_DONE) || (r_state == S_DONE)) begin
            r_irq <= 1'b1;
        end else if (irq_ack) begin
            r_irq <= 1'b0;
        end
    end

    assign irq = r_irq;
`endif

    assign rst_ld  = r_ctrl.rst_ld;
    assign shift   = r_ctrl.shift;
    assign lda2    = r_ctrl.lda2;
    assign q_shift = r_ctrl.q_shift;
    assign q_bit   = r_ctrl.q_bit;
    assign busy    = r_busy;
    assign done    = r_done;
    assign iter    = w_count;

endmodule

// File: tb/tb_sqrt_ctrl.sv
// Self-checking bench for sqrt_ctrl: cycle-by-cycle strobe timelines against an arithmetic sqrt model.
// The irq scenario is compiled in only when SQRT_CTRL_IRQ_EN is defined.
`timescale 1ns/1ps
module tb_sqrt_ctrl;

    localparam int ITER     = 8;
    localparam int DONE_CYC = 3 * ITER + 2;
    localparam int NSIG     = 7;

    logic       clk = 1'b0;
    logic       resetn;
    logic       start;
    logic       sub_neg;
    logic       rst_ld, shift, lda2, q_shift, q_bit, busy, done;
    logic [3:0] iter;
`ifdef SQRT_CTRL_IRQ_EN
    logic         irq;
    logic         irq_ack = 1'b0;
    logic [127:0] ack_pat = '0;
    logic [127:0] rec_irq;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    logic [127:0] rec_v [NSIG];
    logic [127:0] exp_v [NSIG];
    int           rec_iter [128];
    int           exp_iter [128];
    string        sig_name [NSIG] = '{"rst_ld", "shift", "lda2", "q_shift", "q_bit", "busy", "done"};

    always #5 clk = ~clk;

    sqrt_ctrl #(.WIDTH(16)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .start   (start),
        .sub_neg (sub_neg),
`ifdef SQRT_CTRL_IRQ_EN
        .irq_ack (irq_ack),
        .irq     (irq),
`endif
        .rst_ld  (rst_ld),
        .shift   (shift),
        .lda2    (lda2),
        .q_shift (q_shift),
        .q_bit   (q_bit),
        .busy    (busy),
        .done    (done),
        .iter    (iter)
    );

    // Greedy bit-by-bit root: bit k is kept when (2q+1)^2 fits the top 2(k+1) radicand bits.
    function automatic logic [7:0] model_root(input logic [15:0] n);
        int unsigned q;
        int unsigned cand;
        int unsigned part;
        q = 0;
        for (int k = 0; k < ITER; k++) begin
            cand = q * 2 + 1;
            part = 32'(n) >> (2 * (ITER - 1 - k));
            if (cand * cand <= part) q = cand;
            else                     q = q * 2;
        end
        return 8'(q);
    endfunction

    task automatic clear_expect();
        for (int s = 0; s < NSIG; s++) exp_v[s] = '0;
        for (int c = 0; c < 128; c++) exp_iter[c] = 0;
    endtask

    // Expected timeline of one operation whose start is sampled at edge 'base'.
    task automatic add_expect(input logic [15:0] n, input int base);
        logic [7:0] root;
        int         cnt;
        root = model_root(n);
        exp_v[0][base + 1] = 1'b1;
        for (int c = base + 1; c <= base + DONE_CYC; c++) exp_v[5][c] = 1'b1;
        exp_v[6][base + DONE_CYC] = 1'b1;
        for (int k = 0; k < ITER; k++) begin
            exp_v[1][base + 3 * k + 2] = 1'b1;
            exp_v[3][base + 3 * k + 4] = 1'b1;
            if (root[ITER - 1 - k]) begin
                exp_v[2][base + 3 * k + 4] = 1'b1;
                exp_v[4][base + 3 * k + 4] = 1'b1;
            end
        end
        for (int c = base + 2; c < 128; c++) begin
            cnt = 0;
            for (int k = 0; k < ITER; k++) if (base + 3 * k + 4 < c) cnt++;
            exp_iter[c] = cnt;
        end
    endtask

    // Drives start/resetn per cycle and plays the datapath: sub_neg follows the model root.
    task automatic run_capture(input logic [15:0] n, input int ncyc,
                               input logic [127:0] s_pat, input logic [127:0] r_pat);
        logic [7:0] root;
        int         kk;
        root = model_root(n);
        kk   = 0;
        for (int s = 0; s < NSIG; s++) rec_v[s] = '0;
        for (int c = 0; c < 128; c++) rec_iter[c] = 0;
`ifdef SQRT_CTRL_IRQ_EN
        rec_irq = '0;
`endif
        sub_neg = ~root[ITER - 1];
        for (int c = 0; c <= ncyc; c++) begin
            start  = s_pat[c];
            resetn = ~r_pat[c];
`ifdef SQRT_CTRL_IRQ_EN
            irq_ack = ack_pat[c];
`endif
            @(posedge clk);
            @(negedge clk);
            rec_v[0][c + 1] = rst_ld;
            rec_v[1][c + 1] = shift;
            rec_v[2][c + 1] = lda2;
            rec_v[3][c + 1] = q_shift;
            rec_v[4][c + 1] = q_bit;
            rec_v[5][c + 1] = busy;
            rec_v[6][c + 1] = done;
            rec_iter[c + 1] = int'(iter);
`ifdef SQRT_CTRL_IRQ_EN
            rec_irq[c + 1] = irq;
`endif
            if (rst_ld)       kk = 0;
            else if (q_shift) kk++;
            sub_neg = (kk < ITER) ? ~root[ITER - 1 - kk] : 1'b0;
        end
        start  = 1'b0;
        resetn = 1'b1;
`ifdef SQRT_CTRL_IRQ_EN
        irq_ack = 1'b0;
`endif
    endtask

    task automatic test_reset();
        resetn  = 1'b0;
        start   = 1'b0;
        sub_neg = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({rst_ld, shift, lda2, q_shift, q_bit, busy, done} !== 7'b0) begin
            $display("FAIL reset_outputs act=%b exp=0000000", {rst_ld, shift, lda2, q_shift, q_bit, busy, done});
        end else n_pass++;
        n_checks++;
        if (iter !== 4'd0) $display("FAIL reset_iter act=%0d exp=0", iter);
        else n_pass++;
        resetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, rst_ld} !== 3'b0) $display("FAIL idle_after_reset act=%b exp=000", {busy, done, rst_ld});
        else n_pass++;
    endtask

    task automatic test_directed(input string tag, input logic [15:0] n, input logic [7:0] want_root);
        logic [127:0] sp;
        logic [7:0]   got;
        sp = '0; sp[0] = 1'b1;
        clear_expect();
        add_expect(n, 0);
        run_capture(n, 34, sp, '0);
        for (int s = 0; s < NSIG; s++) begin
            n_checks++;
            if (rec_v[s] !== exp_v[s]) $display("FAIL %s_%s act=%h exp=%h", tag, sig_name[s], rec_v[s], exp_v[s]);
            else n_pass++;
        end
        for (int c = 2; c <= 35; c++) begin
            n_checks++;
            if (rec_iter[c] !== exp_iter[c]) $display("FAIL %s_iter cycle %0d act=%0d exp=%0d", tag, c, rec_iter[c], exp_iter[c]);
            else n_pass++;
        end
        got = '0;
        for (int c = 1; c <= 35; c++) if (rec_v[3][c]) got = {got[6:0], rec_v[4][c]};
        n_checks++;
        if (got !== want_root) $display("FAIL %s_root act=%0d exp=%0d", tag, got, want_root);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [127:0] sp;
        logic [15:0]  n;
        logic [7:0]   got;
        sp = '0; sp[0] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            n = 16'($urandom);
            clear_expect();
            add_expect(n, 0);
            run_capture(n, 30, sp, '0);
            for (int s = 0; s < NSIG; s++) begin
                n_checks++;
                if (rec_v[s] !== exp_v[s]) $display("FAIL rand_%0h_%s act=%h exp=%h", n, sig_name[s], rec_v[s], exp_v[s]);
                else n_pass++;
            end
            got = '0;
            for (int c = 1; c <= 31; c++) if (rec_v[3][c]) got = {got[6:0], rec_v[4][c]};
            n_checks++;
            if (!((32'(got) * 32'(got) <= 32'(n)) && ((32'(got) + 1) * (32'(got) + 1) > 32'(n))))
                $display("FAIL rand_root n=%0d act=%0d exp=isqrt", n, got);
            else n_pass++;
        end
    endtask

    task automatic test_start_ignored();
        logic [127:0] sp;
        logic [15:0]  n;
        sp = '0; sp[0] = 1'b1; sp[5] = 1'b1; sp[DONE_CYC] = 1'b1;
        n = 16'($urandom);
        clear_expect();
        add_expect(n, 0);
        run_capture(n, 34, sp, '0);
        for (int s = 0; s < NSIG; s++) begin
            n_checks++;
            if (rec_v[s] !== exp_v[s]) $display("FAIL ignore_%s act=%h exp=%h", sig_name[s], rec_v[s], exp_v[s]);
            else n_pass++;
        end
    endtask

    task automatic test_start_held();
        logic [127:0] sp;
        logic [15:0]  n;
        int           bad;
        sp = '0;
        for (int c = 0; c <= 60; c++) sp[c] = 1'b1;
        n = 16'($urandom);
        clear_expect();
        add_expect(n, 0);
        add_expect(n, DONE_CYC + 1);
        add_expect(n, 2 * (DONE_CYC + 1));
        run_capture(n, 90, sp, '0);
        for (int s = 0; s < NSIG; s++) begin
            n_checks++;
            if (rec_v[s] !== exp_v[s]) $display("FAIL held_%s act=%h exp=%h", sig_name[s], rec_v[s], exp_v[s]);
            else n_pass++;
        end
        bad = 0;
        for (int c = 2; c <= 91; c++) if (rec_iter[c] !== exp_iter[c]) bad++;
        n_checks++;
        if (bad != 0) $display("FAIL held_iter mismatching_cycles act=%0d exp=0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_midop();
        logic [127:0] sp;
        logic [127:0] rp;
        logic [127:0] mask;
        logic [15:0]  n;
        sp = '0; sp[0] = 1'b1;
        rp = '0; rp[10] = 1'b1;
        mask = '0;
        for (int c = 0; c <= 10; c++) mask[c] = 1'b1;
        n = 16'($urandom);
        clear_expect();
        add_expect(n, 0);
        for (int s = 0; s < NSIG; s++) exp_v[s] = exp_v[s] & mask;
        for (int c = 11; c < 128; c++) exp_iter[c] = 0;
        run_capture(n, 34, sp, rp);
        for (int s = 0; s < NSIG; s++) begin
            n_checks++;
            if (rec_v[s] !== exp_v[s]) $display("FAIL midrst_%s act=%h exp=%h", sig_name[s], rec_v[s], exp_v[s]);
            else n_pass++;
        end
        n_checks++;
        if (rec_iter[11] !== 0) $display("FAIL midrst_iter act=%0d exp=0", rec_iter[11]);
        else n_pass++;
        test_directed("after_rst_81", 16'd81, 8'd9);
    endtask

`ifdef SQRT_CTRL_IRQ_EN
    task automatic test_irq();
        logic [127:0] sp;
        logic [127:0] exp_irq;
        sp = '0; sp[0] = 1'b1;
        ack_pat = '0; ack_pat[31] = 1'b1;
        exp_irq = '0;
        for (int c = DONE_CYC; c <= 31; c++) exp_irq[c] = 1'b1;
        run_capture(16'd144, 34, sp, '0);
        n_checks++;
        if (rec_irq !== exp_irq) $display("FAIL irq_sticky act=%h exp=%h", rec_irq, exp_irq);
        else n_pass++;
        ack_pat = '0; ack_pat[DONE_CYC] = 1'b1;
        exp_irq = '0;
        for (int c = DONE_CYC; c <= 35; c++) exp_irq[c] = 1'b1;
        run_capture(16'd144, 34, sp, '0);
        n_checks++;
        if (rec_irq !== exp_irq) $display("FAIL irq_set_wins act=%h exp=%h", rec_irq, exp_irq);
        else n_pass++;
        ack_pat = '0;
    endtask
`endif

    initial begin
        test_reset();
        test_directed("r144", 16'd144, 8'd12);
        test_directed("rffff", 16'hFFFF, 8'd255);
        test_directed("r0", 16'd0, 8'd0);
        test_random();
        test_start_ignored();
        test_start_held();
        test_reset_midop();
`ifdef SQRT_CTRL_IRQ_EN
        test_irq();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
